// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and the round-robin pick function for the cache port arbiter.
package cache_port_arbiter_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } inst_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESPOND
    } arb_state_t;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Walks from ptr upward (mod nreq); iterating downward lets the candidate closest to ptr win.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int                 nreq);
        rr_pick_t         res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                cand = IDX_W'((int'(ptr) + k) % nreq);
                if (req[cand]) begin
                    res.found = 1'b1;
                    res.idx   = cand;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_port_arbiter_rr_arbiter.sv
// Combinational round-robin selector: winner index plus one-hot grant.
module rr_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  request,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] index,
    output logic [NREQ-1:0]  grant
);

    rr_pick_t             pick;
    logic [MAX_REQ-1:0]   req_ext;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = request;
        pick                = rr_pick(req_ext, ptr, NREQ);
        found               = pick.found;
        index               = pick.idx;
        grant               = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = pick.found && (pick.idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache port among NREQ four-phase requesters, one full handshake per grant.
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_request,
    input  inst_t [NREQ-1:0]              req_operation,
    input  logic [NREQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]               req_valid,
    output logic [DATA_W-1:0]             req_rdata,
    output inst_t                         cache_operation,
    output logic [ADDR_W-1:0]             cache_addr,
    output logic [DATA_W-1:0]             cache_wdata,
    output logic                          cache_request,
    input  logic [DATA_W-1:0]             cache_rdata,
    input  logic                          cache_valid,
    output logic                          busy
);

    localparam int OP_W = $bits(inst_t);

    arb_state_t          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    grant;
    logic [NREQ-1:0]     grant_oh;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [NREQ-1:0]     pick_oh;

    logic [OP_W-1:0]     sel_op;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                granted_req;
    logic [IDX_W-1:0]    next_ptr;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .request (req_request),
        .ptr     (rr_ptr),
        .found   (pick_found),
        .index   (pick_idx),
        .grant   (pick_oh)
    );

    // AND-OR mux keyed by the one-hot winner, so no index-width games on the request arrays.
    always_comb begin
        sel_op    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_op    = sel_op    | ({OP_W{pick_oh[i]}}   & req_operation[i]);
            sel_addr  = sel_addr  | ({ADDR_W{pick_oh[i]}} & req_addr[i]);
            sel_wdata = sel_wdata | ({DATA_W{pick_oh[i]}} & req_wdata[i]);
        end
        granted_req = |(req_request & grant_oh);
        next_ptr    = (grant == IDX_W'(NREQ - 1)) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            grant           <= '0;
            grant_oh        <= '0;
            cache_request   <= 1'b0;
            req_valid       <= '0;
            busy            <= 1'b0;
            cache_operation <= READ;
            cache_addr      <= '0;
            cache_wdata     <= '0;
            req_rdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant           <= pick_idx;
                        grant_oh        <= pick_oh;
                        cache_operation <= inst_t'(sel_op);
                        cache_addr      <= sel_addr;
                        cache_wdata     <= sel_wdata;
                        cache_request   <= 1'b1;
                        busy            <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cache_valid) begin
                        req_rdata     <= cache_rdata;
                        cache_request <= 1'b0;
                        state         <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The requester only hears about completion once the cache side is fully closed.
                    if (!cache_valid) begin
                        req_valid <= grant_oh;
                        state     <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (!granted_req) begin
                        req_valid <= '0;
                        rr_ptr    <= next_ptr;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Protocol checks for simulation; the hardware has no recovery path for these.
    a_no_valid_in_idle: assert property (@(posedge clock) disable iff (reset)
        (state == IDLE) |-> !cache_valid);
    a_grant_holds_request: assert property (@(posedge clock) disable iff (reset)
        (state == ISSUE || state == DRAIN) |-> granted_req);

endmodule
